id_stage_decoder: RTL and testbench

Registered instruction-decode stage for the single-issue MIPS-subset core, placed between instruction fetch and the execute stage.
- Decodes a wider opcode/funct set than the previous combinational decoder and sign-extends immediates to the datapath width.
- Holds the decoded bundle in an ID/EX output register with valid/ready handshakes on both sides.
- Inserts a one-cycle bubble on load-use hazards, discards work on branch/jump flush, and keeps a stall counter and a sticky illegal-opcode flag.

---
 rtl/cpu_isa_pkg.sv | 45 ++++
 rtl/id_ctrl_decode.sv | 75 +++++++
 rtl/id_stage_decoder.sv | 159 +++++++++++++++
 tb/tb_id_stage_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants and the decoded-control bundle shared by decode, execute and the ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_isa_pkg;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, inst[5:0]
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU operation codes
    localparam int         ISA_ALUOP_W = 3;
    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_SLT = 3'b100;
    localparam logic [2:0] ALUOP_CMP = 3'b110;  // branch compare

    // Decoded control bundle handed from ID to EX
    typedef struct packed {
        logic                   reg_write;
        logic                   alu_src2;
        logic [ISA_ALUOP_W-1:0] alu_op;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   branch;
        logic                   branch_ne;
        logic                   jump;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode/funct decode into the control bundle plus destination and illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: op/funct/rt/rd instruction fields in; ctrl bundle, wr_addr, illegal out.
module id_ctrl_decode
    import cpu_isa_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl,
    output logic [4:0] wr_addr,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        wr_addr = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                wr_addr        = rd;
                case (funct)
                    F_ADD:   ctrl.alu_op = ALUOP_ADD;
                    F_SUB:   ctrl.alu_op = ALUOP_SUB;
                    F_AND:   ctrl.alu_op = ALUOP_AND;
                    F_OR:    ctrl.alu_op = ALUOP_OR;
                    F_SLT:   ctrl.alu_op = ALUOP_SLT;
                    default: begin
                        ctrl    = '0;
                        wr_addr = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                ctrl.alu_op    = (op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
                ctrl.alu_src2  = 1'b1;
                ctrl.reg_write = 1'b1;
                wr_addr        = rt;
            end
            OP_LW: begin
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.alu_src2   = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                wr_addr         = rt;
            end
            OP_SW: begin
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.alu_src2  = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op    = ALUOP_CMP;
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = (op == OP_BNE);
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // $0 is hard-wired; never report a write to it.
        if (wr_addr == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_decoder.sv
// Registered decode stage: decodes the fetched word into an ID/EX slot with valid/ready on both sides.
// Latency: 1 cycle from accept to ex_valid.
// Backpressure: holds while ex_valid & !ex_ready; one bubble on load-use hazard; flush empties the slot.
// Ports: if_valid/if_ready/if_inst from fetch; flush from EX; ex_* decoded bundle with
//        ex_valid/ex_ready; illegal sticky flag; stall_cnt saturating bubble counter.
module id_stage_decoder
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [31:0]        if_inst,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic               ex_reg_write,
    output logic [REG_AW-1:0]  ex_wr_addr,
    output logic [REG_AW-1:0]  ex_rs_addr,
    output logic [REG_AW-1:0]  ex_rt_addr,
    output logic               ex_alu_src2,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic               ex_branch_ne,
    output logic               ex_jump,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [25:0]        ex_jtarget,
    output logic               illegal,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    ctrl_t       dec_ctrl;
    logic [4:0]  dec_wr_addr;
    logic        dec_illegal;

    ctrl_t              slot_ctrl;
    logic [REG_AW-1:0]  slot_wr_addr;
    logic [REG_AW-1:0]  slot_rs_addr;
    logic [REG_AW-1:0]  slot_rt_addr;
    logic [DATA_W-1:0]  slot_imm;
    logic [25:0]        slot_jtarget;
    logic               illegal_q;
    logic [CNT_W-1:0]   stall_q;

    logic [REG_AW-1:0]  in_rs;
    logic [REG_AW-1:0]  in_rt;
    logic               load_en;
    logic               hazard;
    logic               accept;
    logic               bubble_stall;

    id_ctrl_decode u_dec (
        .op      (if_inst[31:26]),
        .funct   (if_inst[5:0]),
        .rt      (if_inst[20:16]),
        .rd      (if_inst[15:11]),
        .ctrl    (dec_ctrl),
        .wr_addr (dec_wr_addr),
        .illegal (dec_illegal)
    );

    assign in_rs   = REG_AW'(if_inst[25:21]);
    assign in_rt   = REG_AW'(if_inst[20:16]);
    assign load_en = (state == EMPTY) | ex_ready;

    // Load-use check against the bundle still in the slot; once that load
    // drains the hazard clears by itself, so the cost is exactly one bubble.
    assign hazard = if_valid & (state == FULL) & slot_ctrl.mem_read
                  & (slot_wr_addr != '0)
                  & ((slot_wr_addr == in_rs) | (slot_wr_addr == in_rt));

    // Under flush the presented word is swallowed, hence ready regardless of hazard.
    assign if_ready     = !rst & (flush | (load_en & !hazard));
    assign accept       = if_valid & if_ready & !flush;
    assign bubble_stall = hazard & load_en & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (accept) begin
            state_nxt = FULL;
        end else if (load_en) begin
            state_nxt = EMPTY;
        end
    end

    // Payload only moves on accept; on a bubble it is left stale behind ex_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ctrl    <= '0;
            slot_wr_addr <= '0;
            slot_rs_addr <= '0;
            slot_rt_addr <= '0;
            slot_imm     <= '0;
            slot_jtarget <= '0;
        end else if (accept) begin
            slot_ctrl    <= dec_ctrl;
            slot_wr_addr <= REG_AW'(dec_wr_addr);
            slot_rs_addr <= in_rs;
            slot_rt_addr <= in_rt;
            slot_imm     <= {{(DATA_W-16){if_inst[15]}}, if_inst[15:0]};
            slot_jtarget <= if_inst[25:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            if (accept & dec_illegal) begin
                illegal_q <= 1'b1;
            end
            if (bubble_stall && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign ex_valid      = (state == FULL);
    assign ex_reg_write  = slot_ctrl.reg_write;
    assign ex_wr_addr    = slot_wr_addr;
    assign ex_rs_addr    = slot_rs_addr;
    assign ex_rt_addr    = slot_rt_addr;
    assign ex_alu_src2   = slot_ctrl.alu_src2;
    assign ex_alu_op     = ALUOP_W'(slot_ctrl.alu_op);
    assign ex_mem_read   = slot_ctrl.mem_read;
    assign ex_mem_write  = slot_ctrl.mem_write;
    assign ex_mem_to_reg = slot_ctrl.mem_to_reg;
    assign ex_branch     = slot_ctrl.branch;
    assign ex_branch_ne  = slot_ctrl.branch_ne;
    assign ex_jump       = slot_ctrl.jump;
    assign ex_imm        = slot_imm;
    assign ex_jtarget    = slot_jtarget;
    assign illegal       = illegal_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Directed bench for id_stage_decoder with hand-computed expectations.
// Latency: checks ex_* one cycle after each accept.
// Backpressure: exercises hold, load-use bubble and flush.
module tb_id_stage_decoder;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_reg_write;
    logic [4:0]  ex_wr_addr;
    logic [4:0]  ex_rs_addr;
    logic [4:0]  ex_rt_addr;
    logic        ex_alu_src2;
    logic [2:0]  ex_alu_op;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic        ex_jump;
    logic [31:0] ex_imm;
    logic [25:0] ex_jtarget;
    logic        illegal;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_inst       (if_inst),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_reg_write  (ex_reg_write),
        .ex_wr_addr    (ex_wr_addr),
        .ex_rs_addr    (ex_rs_addr),
        .ex_rt_addr    (ex_rt_addr),
        .ex_alu_src2   (ex_alu_src2),
        .ex_alu_op     (ex_alu_op),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_branch_ne  (ex_branch_ne),
        .ex_jump       (ex_jump),
        .ex_imm        (ex_imm),
        .ex_jtarget    (ex_jtarget),
        .illegal       (illegal),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_inst  = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_if_ready",  {31'd0, if_ready},  32'd0);
        chk("rst_ex_valid",  {31'd0, ex_valid},  32'd0);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_imm",       ex_imm,             32'd0);
        chk("rst_wr_addr",   {27'd0, ex_wr_addr}, 32'd0);
        rst = 1'b0;

        // add $3,$1,$2
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_inst  = 32'h0022_1820;
        #1;
        chk("add_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("add_valid",   {31'd0, ex_valid},     32'd1);
        chk("add_aluop",   {29'd0, ex_alu_op},    32'd0);
        chk("add_wr",      {27'd0, ex_wr_addr},   32'd3);
        chk("add_rw",      {31'd0, ex_reg_write}, 32'd1);
        chk("add_rs",      {27'd0, ex_rs_addr},   32'd1);
        chk("add_rt",      {27'd0, ex_rt_addr},   32'd2);
        chk("add_src2",    {31'd0, ex_alu_src2},  32'd0);

        // lw $5,-4($1): no hazard against the add in the slot
        if_inst = 32'h8C25_FFFC;
        tick();
        chk("lw_valid", {31'd0, ex_valid},      32'd1);
        chk("lw_imm",   ex_imm,                 32'hFFFF_FFFC);
        chk("lw_mr",    {31'd0, ex_mem_read},   32'd1);
        chk("lw_m2r",   {31'd0, ex_mem_to_reg}, 32'd1);
        chk("lw_wr",    {27'd0, ex_wr_addr},    32'd5);
        chk("lw_src2",  {31'd0, ex_alu_src2},   32'd1);
        chk("lw_rw",    {31'd0, ex_reg_write},  32'd1);

        // add $6,$5,$2 right behind the load: one bubble
        if_inst = 32'h00A2_3020;
        #1;
        chk("hz_if_ready", {31'd0, if_ready}, 32'd0);
        tick();
        chk("hz_bubble", {31'd0, ex_valid},   32'd0);
        chk("hz_cnt",    {16'd0, stall_cnt},  32'd1);
        chk("hz_ready2", {31'd0, if_ready},   32'd1);
        tick();
        chk("hz_issue_valid", {31'd0, ex_valid},   32'd1);
        chk("hz_issue_wr",    {27'd0, ex_wr_addr}, 32'd6);
        chk("hz_issue_rs",    {27'd0, ex_rs_addr}, 32'd5);
        chk("hz_cnt_hold",    {16'd0, stall_cnt},  32'd1);

        // Backpressure: sub $7,$1,$2 waits while EX is not ready
        ex_ready = 1'b0;
        if_inst  = 32'h0022_3822;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_if_ready", {31'd0, if_ready},   32'd0);
            tick();
            chk("bp_valid",    {31'd0, ex_valid},   32'd1);
            chk("bp_wr",       {27'd0, ex_wr_addr}, 32'd6);
            chk("bp_aluop",    {29'd0, ex_alu_op},  32'd0);
            chk("bp_imm",      ex_imm,              32'h0000_3020);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("sub_wr",    {27'd0, ex_wr_addr}, 32'd7);
        chk("sub_aluop", {29'd0, ex_alu_op},  32'd1);

        // Flush while FULL and stalled: or $8 is dropped
        ex_ready = 1'b0;
        flush    = 1'b1;
        if_inst  = 32'h0022_4025;
        #1;
        chk("fl_if_ready", {31'd0, if_ready}, 32'd1);
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("fl_valid", {31'd0, ex_valid},  32'd0);
        chk("fl_cnt",   {16'd0, stall_cnt}, 32'd1);
        tick();
        chk("fl_dropped", {31'd0, ex_valid}, 32'd0);

        // Illegal opcode 0x3F: NOP bundle, still valid, sticky flag
        ex_ready = 1'b1;
        if_valid = 1'b1;
        if_inst  = 32'hFC00_0000;
        tick();
        chk("ill_valid", {31'd0, ex_valid},     32'd1);
        chk("ill_flag",  {31'd0, illegal},      32'd1);
        chk("ill_rw",    {31'd0, ex_reg_write}, 32'd0);
        chk("ill_mr",    {31'd0, ex_mem_read},  32'd0);
        chk("ill_jump",  {31'd0, ex_jump},      32'd0);

        // addi $0,$1,5: write to $0 suppressed
        if_inst = 32'h2020_0005;
        tick();
        chk("addi0_rw",   {31'd0, ex_reg_write}, 32'd0);
        chk("addi0_src2", {31'd0, ex_alu_src2},  32'd1);
        chk("addi0_imm",  ex_imm,                32'd5);
        chk("ill_sticky", {31'd0, illegal},      32'd1);

        // bne $1,$2,-1
        if_inst = 32'h1422_FFFF;
        tick();
        chk("bne_br",    {31'd0, ex_branch},    32'd1);
        chk("bne_ne",    {31'd0, ex_branch_ne}, 32'd1);
        chk("bne_aluop", {29'd0, ex_alu_op},    32'd6);
        chk("bne_rw",    {31'd0, ex_reg_write}, 32'd0);

        // j 0x0123456
        if_inst = 32'h0812_3456;
        tick();
        chk("j_jump", {31'd0, ex_jump},    32'd1);
        chk("j_tgt",  {6'd0, ex_jtarget},  32'h0012_3456);
        chk("j_br",   {31'd0, ex_branch},  32'd0);

        // sw $5,8($1)
        if_inst = 32'hAC25_0008;
        tick();
        chk("sw_mw", {31'd0, ex_mem_write}, 32'd1);
        chk("sw_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("sw_wr", {27'd0, ex_wr_addr},   32'd0);

        // slt $3,$1,$2 and unlisted R-type funct 0x3F
        if_inst = 32'h0022_182A;
        tick();
        chk("slt_aluop", {29'd0, ex_alu_op}, 32'd4);
        chk("slt_wr",    {27'd0, ex_wr_addr}, 32'd3);
        if_inst = 32'h0022_183F;
        tick();
        chk("badfn_rw",  {31'd0, ex_reg_write}, 32'd0);
        chk("badfn_wr",  {27'd0, ex_wr_addr},   32'd0);

        // Idle input with EX ready drains the slot
        if_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, ex_valid}, 32'd0);

        // Reset mid-transfer clears the slot and sticky state
        if_valid = 1'b1;
        if_inst  = 32'h0022_1820;
        tick();
        rst = 1'b1;
        #1;
        chk("rst2_valid",   {31'd0, ex_valid},  32'd0);
        chk("rst2_illegal", {31'd0, illegal},   32'd0);
        chk("rst2_cnt",     {16'd0, stall_cnt}, 32'd0);
        chk("rst2_ready",   {31'd0, if_ready},  32'd0);
        rst = 1'b0;
        if_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
